mano_mem_sequencer: RTL and testbench
=====================================

Name: mano_mem_sequencer

Overview:
- Sequences every memory access of the Mano basic computer.
- Accepts the decoded read/write strobes from control logic (READ/WRITE timing terms) and drives the RAM port with programmable wait states.
- Freezes the sequence counter (T-state advance) until the access completes.
- Returns read data to the DR/IR load path with a valid pulse.

Parameters:
- ADDR_W, 12, memory address width (AR width).
- DATA_W, 16, memory word width.
- WAIT_CYCLES, 1, extra cycles mem_en is held beyond the first; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- rd_req  input  1  read strobe from control decode, level, held while stalled.
- wr_req  input  1  write strobe from control decode, level, held while stalled.
- addr_in  input  ADDR_W  address (AR contents).
- wdata_in  input  DATA_W  write data (DR/AC contents).
- mem_rdata  input  DATA_W  RAM read data, valid in any cycle mem_en=1 and mem_we=0.
- mem_addr  output  ADDR_W  registered RAM address.
- mem_wdata  output  DATA_W  registered RAM write data.
- mem_en  output  1  RAM enable.
- mem_we  output  1  RAM write enable, qualified by mem_en.
- rdata  output  DATA_W  captured read word, holds until next read completes.
- rdata_valid  output  1  one-cycle pulse, read completed.
- ack  output  1  one-cycle pulse, any access completed.
- stall  output  1  combinational, freezes sequence counter.
- busy  output  1  registered, state != IDLE.
- err_conflict  output  1  sticky, set when rd_req and wr_req are sampled together; cleared only by rst.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE.
  - mem_addr=0, mem_wdata=0, mem_en=0, mem_we=0, rdata=0, rdata_valid=0, ack=0, busy=0, err_conflict=0, wait counter=0.
  - Reset mid-access aborts the access: no ack and no rdata_valid are issued afterward, and rdata is cleared.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If rd_req|wr_req: latch addr_in into mem_addr, latch wdata_in into mem_wdata, set we_lat=wr_req&~rd_req, load cnt=WAIT_CYCLES, go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - mem_en=1, mem_we=we_lat.
  - If cnt!=0: cnt-=1, stay in ACCESS.
  - If cnt==0: if read, capture mem_rdata into rdata on this edge; go to DONE.
- DONE:
  - ack=1; rdata_valid=1 if the access was a read.
  - mem_en=0, mem_we=0.
  - Go to IDLE unconditionally; requests present in DONE are ignored.
- stall = (IDLE & (rd_req|wr_req)) | ACCESS. stall is 0 in DONE so the sequence counter advances at the end of DONE.
- Latency: request first seen in IDLE at cycle 0.
  - mem_en high in cycles 1..1+WAIT_CYCLES.
  - ack/rdata_valid in cycle 2+WAIT_CYCLES.
  - Total 3+WAIT_CYCLES cycles per access.
- Simultaneous rd_req and wr_req in IDLE: read wins, err_conflict set (sticky).
- Requests changing during ACCESS have no effect; latched address, data and type are used.
- Back-to-back: a request held through DONE starts a new access in the following IDLE cycle (one idle bubble).
- mem_addr and mem_wdata hold their last values in IDLE and DONE.
- WAIT_CYCLES=0: ACCESS lasts exactly one cycle.

Optional Feature:
- Macro: MANO_MEM_SEQ_STATS_EN.
- Defined:
  - Adds outputs rd_count and wr_count, 16 bits each.
  - Each increments by 1 in the DONE cycle of a read or write respectively.
  - Each saturates at 16'hFFFF.
  - Both reset to 0 on rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst held 2 cycles mid-ACCESS -> next cycle all outputs 0, state IDLE, no ack ever follows for the aborted access.
- Read, WAIT_CYCLES=1: rd_req=1, addr_in=12'h0A5, mem_rdata=16'h7123 -> mem_en=1 in cycles 1-2 with mem_addr=12'h0A5 and mem_we=0; cycle 3 ack=1, rdata_valid=1, rdata=16'h7123, stall=0; stall=1 in cycles 0-2.
- Write, WAIT_CYCLES=0: wr_req=1, addr_in=12'hFFF, wdata_in=16'hBEEF -> cycle 1 mem_en=1, mem_we=1, mem_addr=12'hFFF, mem_wdata=16'hBEEF; cycle 2 ack=1, rdata_valid=0, rdata unchanged.
- Conflict: rd_req=wr_req=1 in IDLE -> read performed (mem_we=0 throughout), err_conflict=1 and still 1 after 10 idle cycles, cleared only by rst.
- Back-to-back: rd_req held high for 9 cycles with WAIT_CYCLES=1 -> acks in cycles 3 and 7, IDLE bubble in cycles 4 and 8; addr_in changed in cycle 2 does not alter mem_addr until cycle 5.
- With MANO_MEM_SEQ_STATS_EN: 3 reads then 2 writes -> rd_count=3, wr_count=2; force rd_count to 16'hFFFE, do 2 reads -> rd_count=16'hFFFF.

Source files
------------

// File: rtl/mano_mem_sequencer.sv
// Memory access sequencer for the Mano basic computer.
// Turns level read/write strobes from control decode into a RAM access with
// WAIT_CYCLES extra enable cycles, and stalls the sequence counter until done.
// Optional build macro: MANO_MEM_SEQ_STATS_EN adds saturating rd/wr counters.
//
// state  | meaning
// IDLE   | waiting for rd_req/wr_req; latches address, data and type on request
// ACCESS | RAM enabled; counts down wait states, captures read data on last
// DONE   | ack (and rdata_valid for reads) pulse; requests ignored
module mano_mem_sequencer #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              ack,
  output logic              stall,
  output logic              busy,
`ifdef MANO_MEM_SEQ_STATS_EN
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
`endif
  output logic              err_conflict
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [3:0]          r_cnt;
  logic                r_we_lat;
  logic                r_busy;
  logic                r_err;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_req;

  assign w_req        = rd_req | wr_req;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign rdata        = r_rdata;
  assign busy         = r_busy;
  assign err_conflict = r_err;

  // Next-state decode plus the state-derived strobes (enable, ack, stall).
  always_comb begin
    w_next      = r_state;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    ack         = 1'b0;
    rdata_valid = 1'b0;
    stall       = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall = w_req;
        if (w_req) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        mem_en = 1'b1;
        mem_we = r_we_lat;
        stall  = 1'b1;
        if (r_cnt == 4'd0) w_next = S_DONE;
      end
      S_DONE: begin
        ack         = 1'b1;
        rdata_valid = ~r_we_lat;
        w_next      = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register, request latching, wait-state countdown and read capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_cnt       <= 4'd0;
      r_we_lat    <= 1'b0;
      r_err       <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_mem_addr  <= addr_in;
            r_mem_wdata <= wdata_in;
            // read wins a simultaneous request; the conflict is remembered
            r_we_lat    <= wr_req & ~rd_req;
            r_cnt       <= 4'(WAIT_CYCLES);
            if (rd_req & wr_req) r_err <= 1'b1;
          end
        end
        S_ACCESS: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else if (!r_we_lat) begin
            r_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MANO_MEM_SEQ_STATS_EN
  logic [15:0] r_rd_count;
  logic [15:0] r_wr_count;

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;

  // Saturating completion counters, bumped on the DONE cycle of each access.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_count <= 16'd0;
      r_wr_count <= 16'd0;
    end else if (r_state == S_DONE) begin
      if (!r_we_lat && r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
      if (r_we_lat && r_wr_count != 16'hFFFF)  r_wr_count <= r_wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mano_mem_sequencer.sv
// Directed bench for mano_mem_sequencer: one instance with WAIT_CYCLES=1
// driven from a per-cycle vector table, one with WAIT_CYCLES=0 driven by hand.
module tb_mano_mem_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WAIT_CYCLES=1 instance
  logic        rd1, wr1;
  logic [11:0] addr1;
  logic [15:0] wd1, mrd1;
  logic [11:0] maddr1;
  logic [15:0] mwd1, rdata1;
  logic        en1, we1, rv1, ack1, stall1, busy1, err1;

  // WAIT_CYCLES=0 instance
  logic        rd0, wr0;
  logic [11:0] addr0;
  logic [15:0] wd0, mrd0;
  logic [11:0] maddr0;
  logic [15:0] mwd0, rdata0;
  logic        en0, we0, rv0, ack0, stall0, busy0, err0;

`ifdef MANO_MEM_SEQ_STATS_EN
  logic [15:0] rdc1, wrc1, rdc0, wrc0;
`endif

  mano_mem_sequencer #(.ADDR_W(12), .DATA_W(16), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .rd_req(rd1), .wr_req(wr1), .addr_in(addr1),
    .wdata_in(wd1), .mem_rdata(mrd1), .mem_addr(maddr1), .mem_wdata(mwd1),
    .mem_en(en1), .mem_we(we1), .rdata(rdata1), .rdata_valid(rv1),
    .ack(ack1), .stall(stall1), .busy(busy1),
`ifdef MANO_MEM_SEQ_STATS_EN
    .rd_count(rdc1), .wr_count(wrc1),
`endif
    .err_conflict(err1)
  );

  mano_mem_sequencer #(.ADDR_W(12), .DATA_W(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .rd_req(rd0), .wr_req(wr0), .addr_in(addr0),
    .wdata_in(wd0), .mem_rdata(mrd0), .mem_addr(maddr0), .mem_wdata(mwd0),
    .mem_en(en0), .mem_we(we0), .rdata(rdata0), .rdata_valid(rv0),
    .ack(ack0), .stall(stall0), .busy(busy0),
`ifdef MANO_MEM_SEQ_STATS_EN
    .rd_count(rdc0), .wr_count(wrc0),
`endif
    .err_conflict(err0)
  );

  typedef struct {
    logic        rd, wr;
    logic [11:0] addr;
    logic [15:0] wd, mrd;
    logic        en, we;
    logic [11:0] maddr;
    logic        ack, rv, stall, busy, err;
    logic [15:0] rdata;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rd, input logic wr, input logic [11:0] addr,
                     input logic [15:0] wd, input logic [15:0] mrd,
                     input logic en, input logic we, input logic [11:0] maddr,
                     input logic ack, input logic rv, input logic stall,
                     input logic busy, input logic err, input logic [15:0] rdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.mrd = mrd;
    v.en = en; v.we = we; v.maddr = maddr; v.ack = ack; v.rv = rv;
    v.stall = stall; v.busy = busy; v.err = err; v.rdata = rdata;
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    rd1 = 0; wr1 = 0; addr1 = 0; wd1 = 0; mrd1 = 0;
    rd0 = 0; wr0 = 0; addr0 = 0; wd0 = 0; mrd0 = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); @(posedge clk); #1 rst = 0;
  endtask

`ifdef MANO_MEM_SEQ_STATS_EN
  task automatic access1(input logic rd, input logic wr, input string nm);
    bit seen = 0;
    @(posedge clk); #1 rd1 = rd; wr1 = wr; addr1 = 12'h040; wd1 = 16'h1234;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack1) begin seen = 1; break; end
    end
    rd1 = 0; wr1 = 0;
    chk({nm, "_ack_seen"}, 32'(seen), 32'd1);
    @(posedge clk);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    idle_inputs();
    do_reset();
    @(negedge clk);
    chk("rst_en", 32'(en1), 0);   chk("rst_ack", 32'(ack1), 0);
    chk("rst_busy", 32'(busy1), 0); chk("rst_rdata", 32'(rdata1), 0);
    chk("rst_maddr", 32'(maddr1), 0); chk("rst_err", 32'(err1), 0);

    //    rd wr addr     wd       mrd      en we maddr   ack rv st bz er rdata
    // single read
    add(1, 0, 12'h0A5, 16'h0,  16'h0000, 0, 0, 12'h000, 0, 0, 1, 0, 0, 16'h0000);
    add(1, 0, 12'h0A5, 16'h0,  16'h1111, 1, 0, 12'h0A5, 0, 0, 1, 1, 0, 16'h0000);
    add(1, 0, 12'h0A5, 16'h0,  16'h7123, 1, 0, 12'h0A5, 0, 0, 1, 1, 0, 16'h0000);
    add(0, 0, 12'h0A5, 16'h0,  16'h0000, 0, 0, 12'h0A5, 1, 1, 0, 1, 0, 16'h7123);
    add(0, 0, 12'h0A5, 16'h0,  16'h0000, 0, 0, 12'h0A5, 0, 0, 0, 0, 0, 16'h7123);
    // back-to-back reads, addr_in changes in cycle 2
    add(1, 0, 12'h0A0, 16'h0,  16'h0000, 0, 0, 12'h0A5, 0, 0, 1, 0, 0, 16'h7123);
    add(1, 0, 12'h0A0, 16'h0,  16'h0000, 1, 0, 12'h0A0, 0, 0, 1, 1, 0, 16'h7123);
    add(1, 0, 12'h0B0, 16'h0,  16'h2222, 1, 0, 12'h0A0, 0, 0, 1, 1, 0, 16'h7123);
    add(1, 0, 12'h0B0, 16'h0,  16'h0000, 0, 0, 12'h0A0, 1, 1, 0, 1, 0, 16'h2222);
    add(1, 0, 12'h0B0, 16'h0,  16'h0000, 0, 0, 12'h0A0, 0, 0, 1, 0, 0, 16'h2222);
    add(1, 0, 12'h0B0, 16'h0,  16'h0000, 1, 0, 12'h0B0, 0, 0, 1, 1, 0, 16'h2222);
    add(1, 0, 12'h0B0, 16'h0,  16'h3333, 1, 0, 12'h0B0, 0, 0, 1, 1, 0, 16'h2222);
    add(1, 0, 12'h0B0, 16'h0,  16'h0000, 0, 0, 12'h0B0, 1, 1, 0, 1, 0, 16'h3333);
    add(1, 0, 12'h0B0, 16'h0,  16'h0000, 0, 0, 12'h0B0, 0, 0, 1, 0, 0, 16'h3333);
    add(0, 0, 12'h0B0, 16'h0,  16'h0000, 1, 0, 12'h0B0, 0, 0, 1, 1, 0, 16'h3333);
    add(0, 0, 12'h0B0, 16'h0,  16'h4444, 1, 0, 12'h0B0, 0, 0, 1, 1, 0, 16'h3333);
    add(0, 0, 12'h0B0, 16'h0,  16'h0000, 0, 0, 12'h0B0, 1, 1, 0, 1, 0, 16'h4444);
    add(0, 0, 12'h0B0, 16'h0,  16'h0000, 0, 0, 12'h0B0, 0, 0, 0, 0, 0, 16'h4444);
    // simultaneous read and write: read wins, conflict flagged
    add(1, 1, 12'h123, 16'h5555, 16'h0000, 0, 0, 12'h0B0, 0, 0, 1, 0, 0, 16'h4444);
    add(1, 1, 12'h123, 16'h5555, 16'h0000, 1, 0, 12'h123, 0, 0, 1, 1, 1, 16'h4444);
    add(1, 1, 12'h123, 16'h5555, 16'h6666, 1, 0, 12'h123, 0, 0, 1, 1, 1, 16'h4444);
    add(0, 0, 12'h123, 16'h0,    16'h0000, 0, 0, 12'h123, 1, 1, 0, 1, 1, 16'h6666);
    add(0, 0, 12'h123, 16'h0,    16'h0000, 0, 0, 12'h123, 0, 0, 0, 0, 1, 16'h6666);

    foreach (vq[i]) begin
      @(posedge clk); #1;
      rd1 = vq[i].rd; wr1 = vq[i].wr; addr1 = vq[i].addr;
      wd1 = vq[i].wd; mrd1 = vq[i].mrd;
      @(negedge clk);
      chk($sformatf("v%0d_en", i),    32'(en1),    32'(vq[i].en));
      chk($sformatf("v%0d_we", i),    32'(we1),    32'(vq[i].we));
      chk($sformatf("v%0d_maddr", i), 32'(maddr1), 32'(vq[i].maddr));
      chk($sformatf("v%0d_ack", i),   32'(ack1),   32'(vq[i].ack));
      chk($sformatf("v%0d_rv", i),    32'(rv1),    32'(vq[i].rv));
      chk($sformatf("v%0d_stall", i), 32'(stall1), 32'(vq[i].stall));
      chk($sformatf("v%0d_busy", i),  32'(busy1),  32'(vq[i].busy));
      chk($sformatf("v%0d_err", i),   32'(err1),   32'(vq[i].err));
      chk($sformatf("v%0d_rdata", i), 32'(rdata1), 32'(vq[i].rdata));
    end
    chk("conflict_wdata", 32'(mwd1), 32'h5555);

    // conflict flag is sticky across idle cycles
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("err_sticky_%0d", k), 32'(err1), 1);
    end
    do_reset();
    @(negedge clk);
    chk("err_cleared", 32'(err1), 0);
    chk("rst_rdata_cleared", 32'(rdata1), 0);
    chk("rst_maddr_cleared", 32'(maddr1), 0);

    // reset held two cycles in the middle of an access aborts it
    @(posedge clk); #1 rd1 = 1; addr1 = 12'h055; mrd1 = 16'h9999;
    @(posedge clk); #1 rd1 = 0;
    @(negedge clk);
    chk("abort_in_access", 32'(en1), 1);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("abort_en", 32'(en1), 0);     chk("abort_we", 32'(we1), 0);
    chk("abort_ack", 32'(ack1), 0);   chk("abort_rv", 32'(rv1), 0);
    chk("abort_busy", 32'(busy1), 0); chk("abort_stall", 32'(stall1), 0);
    chk("abort_rdata", 32'(rdata1), 0); chk("abort_maddr", 32'(maddr1), 0);
    chk("abort_mwd", 32'(mwd1), 0);   chk("abort_err", 32'(err1), 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("abort_no_ack_%0d", k), 32'({ack1, rv1, busy1}), 0);
    end

    // WAIT_CYCLES=0: read then write
    @(posedge clk); #1 rd0 = 1; addr0 = 12'h010; mrd0 = 16'h0ABC;
    @(negedge clk);
    chk("w0_rd_c0_stall", 32'(stall0), 1); chk("w0_rd_c0_en", 32'(en0), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w0_rd_c1_en", 32'(en0), 1); chk("w0_rd_c1_we", 32'(we0), 0);
    chk("w0_rd_c1_maddr", 32'(maddr0), 32'h010);
    @(posedge clk); #1 rd0 = 0; mrd0 = 16'h0;
    @(negedge clk);
    chk("w0_rd_c2_ack", 32'(ack0), 1); chk("w0_rd_c2_rv", 32'(rv0), 1);
    chk("w0_rd_c2_rdata", 32'(rdata0), 32'h0ABC); chk("w0_rd_c2_en", 32'(en0), 0);
    @(posedge clk); #1 wr0 = 1; addr0 = 12'hFFF; wd0 = 16'hBEEF; mrd0 = 16'hDEAD;
    @(negedge clk);
    chk("w0_wr_c0_stall", 32'(stall0), 1); chk("w0_wr_c0_busy", 32'(busy0), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w0_wr_c1_en", 32'(en0), 1); chk("w0_wr_c1_we", 32'(we0), 1);
    chk("w0_wr_c1_maddr", 32'(maddr0), 32'hFFF);
    chk("w0_wr_c1_mwd", 32'(mwd0), 32'hBEEF);
    chk("w0_wr_c1_stall", 32'(stall0), 1);
    @(posedge clk); #1 wr0 = 0;
    @(negedge clk);
    chk("w0_wr_c2_ack", 32'(ack0), 1); chk("w0_wr_c2_rv", 32'(rv0), 0);
    chk("w0_wr_c2_rdata", 32'(rdata0), 32'h0ABC);
    chk("w0_wr_c2_stall", 32'(stall0), 0); chk("w0_wr_c2_we", 32'(we0), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w0_wr_c3_busy", 32'(busy0), 0);
    chk("w0_wr_c3_mwd_hold", 32'(mwd0), 32'hBEEF);

`ifdef MANO_MEM_SEQ_STATS_EN
    do_reset();
    @(negedge clk);
    chk("stat_rst_rd", 32'(rdc1), 0); chk("stat_rst_wr", 32'(wrc1), 0);
    access1(1, 0, "s_rd0"); access1(1, 0, "s_rd1"); access1(1, 0, "s_rd2");
    access1(0, 1, "s_wr0"); access1(0, 1, "s_wr1");
    @(negedge clk);
    chk("stat_rd_count", 32'(rdc1), 3); chk("stat_wr_count", 32'(wrc1), 2);
    @(posedge clk); #1 force dut1.r_rd_count = 16'hFFFE;
    @(posedge clk); #1 release dut1.r_rd_count;
    access1(1, 0, "s_sat0"); access1(1, 0, "s_sat1");
    @(negedge clk);
    chk("stat_rd_sat", 32'(rdc1), 32'hFFFF); chk("stat_wr_keep", 32'(wrc1), 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
